// File: rtl/ddr4_v2_2_24_tg_mpfifo_drain_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_v2_2_24_tg_mpfifo_drain_if
//  Purpose  : Bundle of the multiport-FIFO read side and the single-lane
//             valid/ready output stream used by the TG FIFO drain engine.
//  Signals  : fifo_cnt/fifo_empty/fifo_dout  FIFO status and read lanes
//             fifo_rden                      per-lane pop request
//             out_valid/out_ready/out_data/out_last  output stream
//             busy, drained_cnt              status
//  Modports : slave  - the drain engine
//             master - the FIFO/consumer environment
//  Revision : 1.0 - initial release
// ============================================================================
interface ddr4_v2_2_24_tg_mpfifo_drain_if #(
  parameter int WIDTH     = 576,
  parameter int LOG2DEPTH = 2,
  parameter int NUM_PORT  = 4
);
  logic [LOG2DEPTH:0]          fifo_cnt;
  logic                        fifo_empty;
  logic [NUM_PORT*WIDTH-1:0]   fifo_dout;
  logic [NUM_PORT-1:0]         fifo_rden;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_last;
  logic                        busy;
  logic [31:0]                 drained_cnt;

  modport slave (
    input  fifo_cnt, fifo_empty, fifo_dout, out_ready,
    output fifo_rden, out_valid, out_data, out_last, busy, drained_cnt
  );

  modport master (
    output fifo_cnt, fifo_empty, fifo_dout, out_ready,
    input  fifo_rden, out_valid, out_data, out_last, busy, drained_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ddr4_v2_2_24_tg_mpfifo_drain.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_v2_2_24_tg_mpfifo_drain
//  Purpose  : Read-side engine for the TG multiport FIFO. In IDLE it pops up
//             to NUM_PORT entries in one cycle into a local burst buffer,
//             then serialises the buffer onto a single-lane valid/ready
//             stream in strict FIFO order (lane 0 first).
//  Ports    : clk, rst_n (asynchronous, active-low)
//             bus (slave modport of ddr4_v2_2_24_tg_mpfifo_drain_if)
//  Options  : TG_MPFIFO_DRAIN_STATS_EN - when defined, drained_cnt is a
//             saturating 32-bit count of accepted beats; otherwise it is 0.
//  Notes    : NUM_PORT must be >= 2 and <= 2**LOG2DEPTH. TCQ is kept for
//             interface compatibility; registers carry no modelled delay.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr4_v2_2_24_tg_mpfifo_drain #(
  parameter int TCQ          = 100,
  parameter int WIDTH        = 576,
  parameter int LOG2DEPTH    = 2,
  parameter int NUM_PORT     = 4,
  parameter int LOG2NUM_PORT = 2
) (
  input  wire                             clk,
  input  wire                             rst_n,
  ddr4_v2_2_24_tg_mpfifo_drain_if.slave   bus
);

  localparam int c_CW = LOG2DEPTH + 1;     // fifo_cnt width
  localparam int c_IW = LOG2NUM_PORT + 1;  // idx/len width

  if (TCQ < 0 || NUM_PORT < 2 || NUM_PORT > (1 << LOG2DEPTH)) begin : g_bad_param
    $error("ddr4_v2_2_24_tg_mpfifo_drain: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IW-1:0]    r_idx;
  logic [c_IW-1:0]    r_len;
  logic               r_out_valid;
  logic               r_out_last;
  logic [WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]   r_buf [NUM_PORT];

  logic [WIDTH-1:0]   w_lane [NUM_PORT];
  logic [c_CW-1:0]    w_n;
  logic [c_IW-1:0]    w_len;
  logic [c_IW-1:0]    w_idx_nxt;
  logic [NUM_PORT-1:0] w_therm;
  logic               w_fetch;

  for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_lane
    assign w_lane[gi] = bus.fifo_dout[gi*WIDTH +: WIDTH];
  end

  // Entries to take this fetch: min(fifo_cnt, NUM_PORT).
  assign w_n = (bus.fifo_cnt > c_CW'(NUM_PORT)) ? c_CW'(NUM_PORT) : bus.fifo_cnt;
  assign w_len = c_IW'(w_n);
  assign w_idx_nxt = r_idx + c_IW'(1);

  // Fetches happen only from IDLE, so the FIFO never sees a pop while a
  // burst is still being delivered.
  assign w_fetch = (r_state == S_IDLE) && !bus.fifo_empty && (w_n != '0);

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (i < int'(w_n)) w_therm[i] = 1'b1;
    end
  end

  // Reset gates the pop request combinationally so nothing is popped while
  // the FIFO and this block are held in reset.
  assign bus.fifo_rden = (w_fetch && rst_n) ? w_therm : '0;

  // Burst buffer: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (i < int'(w_n)) r_buf[i] <= w_lane[i];
      end
    end
  end

  // Control FSM with registered stream outputs. out_data/out_last are
  // preloaded with the next beat so they are stable for the whole time a
  // beat waits on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fetch) begin
            r_state     <= S_DRAIN;
            r_len       <= w_len;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (w_len == c_IW'(1));
            r_out_data  <= w_lane[0];  // lane 0 bypasses the buffer
          end
        end
        S_DRAIN: begin
          if (r_out_valid && bus.out_ready) begin
            if (r_out_last) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_buf[w_idx_nxt[LOG2NUM_PORT-1:0]];
              r_out_last <= (w_idx_nxt == (r_len - c_IW'(1)));
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_out_valid;

`ifdef TG_MPFIFO_DRAIN_STATS_EN
  logic [31:0] r_drained_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drained_cnt <= '0;
    end else if (r_out_valid && bus.out_ready && (r_drained_cnt != 32'hFFFF_FFFF)) begin
      r_drained_cnt <= r_drained_cnt + 32'd1;
    end
  end

  assign bus.drained_cnt = r_drained_cnt;
`else
  assign bus.drained_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr4_v2_2_24_tg_mpfifo_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr4_v2_2_24_tg_mpfifo_drain
//  Purpose  : Self-checking bench for the TG multiport FIFO drain engine.
//             A behavioural FIFO feeds the DUT; written entries go to a
//             scoreboard queue and are compared against accepted beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_v2_2_24_tg_mpfifo_drain;

  localparam int W     = 576;
  localparam int LD    = 2;
  localparam int NP    = 4;
  localparam int LNP   = 2;
  localparam int DEPTH = 1 << LD;

  logic clk;
  logic rst_n;

  ddr4_v2_2_24_tg_mpfifo_drain_if #(.WIDTH(W), .LOG2DEPTH(LD), .NUM_PORT(NP)) bus ();

  ddr4_v2_2_24_tg_mpfifo_drain #(
    .TCQ(100), .WIDTH(W), .LOG2DEPTH(LD), .NUM_PORT(NP), .LOG2NUM_PORT(LNP)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] fifo_q [$];
  logic [W-1:0] src_q  [$];
  logic [W-1:0] exp_q  [$];

  // Reference model of the drain engine's externally visible state.
  bit          m_drain = 1'b0;
  int          m_rem   = 0;
  logic [31:0] m_acc   = '0;

  int stall_cnt   = 0;
  bit rnd_ready   = 1'b0;
  bit rnd_refill  = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {(W/32){w}};
  endfunction

  function automatic logic [NP-1:0] therm(input int n);
    logic [NP-1:0] r;
    r = '0;
    for (int i = 0; i < NP; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  task automatic add(input int k);
    src_q.push_back(mk(k));
    exp_q.push_back(mk(k));
  endtask

  task automatic drive_fifo();
    bus.fifo_cnt   = (LD+1)'(fifo_q.size());
    bus.fifo_empty = (fifo_q.size() == 0);
    for (int i = 0; i < NP; i++)
      bus.fifo_dout[i*W +: W] = (i < fifo_q.size()) ? fifo_q[i] : '0;
  endtask

  // One clock: check at the falling edge, then update environment after
  // the rising edge.
  task automatic cycle();
    int n;
    int pops;
    int lim;
    logic [31:0] exp_stats;
    @(negedge clk);
    n = (fifo_q.size() > NP) ? NP : fifo_q.size();
    chk("rden",  W'(bus.fifo_rden), W'(m_drain ? '0 : therm(n)));
    chk("valid", W'(bus.out_valid), W'(m_drain));
    chk("busy",  W'(bus.busy),      W'(m_drain));
    chk("last",  W'(bus.out_last),  W'(m_drain && m_rem == 1));
    if (m_drain && exp_q.size() > 0) chk("data", bus.out_data, exp_q[0]);
`ifdef TG_MPFIFO_DRAIN_STATS_EN
    exp_stats = m_acc;
`else
    exp_stats = '0;
`endif
    chk("stats", W'(bus.drained_cnt), W'(exp_stats));

    if (m_drain && bus.out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_rem--;
      if (m_rem == 0) m_drain = 1'b0;
      if (m_acc != 32'hFFFF_FFFF) m_acc++;
    end else if (!m_drain && n != 0) begin
      m_drain = 1'b1;
      m_rem   = n;
    end
    pops = $countones(bus.fifo_rden);

    @(posedge clk);
    #1;
    for (int i = 0; i < pops; i++) if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    lim = rnd_refill ? int'($urandom_range(0, 2)) : DEPTH;
    for (int i = 0; i < lim; i++)
      if (fifo_q.size() < DEPTH && src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
    end else begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    drive_fifo();
  endtask

  task automatic run_until_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while ((m_drain || src_q.size() > 0 || fifo_q.size() > 0) && cycles < budget) begin
      cycle();
      cycles++;
    end
    chk({tag, "_idle"}, W'(m_drain || src_q.size() > 0 || fifo_q.size() > 0), W'(0));
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    src_q.delete();
    m_drain = 1'b0;
    m_rem   = 0;
    m_acc   = '0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", W'(bus.out_valid), W'(0));
    chk("rst_busy",  W'(bus.busy),      W'(0));
    chk("rst_last",  W'(bus.out_last),  W'(0));
    chk("rst_data",  bus.out_data,      W'(0));
    chk("rst_stats", W'(bus.drained_cnt), W'(0));
    chk("rst_rden",  W'(bus.fifo_rden), W'(0));
    rst_n = 1'b1;

    // Four entries, ready always high: one fetch + four beats.
    for (int k = 0; k < 4; k++) add(k);
    run_until_idle("t1", 50, cyc);
    chk("t1_cycles", W'(cyc), W'(6));

    // Idle with an empty FIFO: no pops.
    repeat (3) cycle();

    // Two entries.
    for (int k = 10; k < 12; k++) add(k);
    run_until_idle("t2", 50, cyc);
    chk("t2_cycles", W'(cyc), W'(4));

    // Three entries with the first beat stalled for five cycles.
    stall_cnt = 6;
    for (int k = 20; k < 23; k++) add(k);
    run_until_idle("t3", 50, cyc);
    chk("t3_cycles", W'(cyc), W'(10));

    // Twelve entries with the FIFO kept full: three 5-cycle bursts.
    for (int k = 30; k < 42; k++) add(k);
    run_until_idle("t4", 100, cyc);
    chk("t4_cycles", W'(cyc), W'(16));

    // Reset in the middle of a burst after one accepted beat.
    for (int k = 50; k < 54; k++) add(k);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_busy",  W'(bus.busy),      W'(0));
    chk("mid_rst_rden",  W'(bus.fifo_rden), W'(0));
    chk("mid_rst_stats", W'(bus.drained_cnt), W'(0));
    fifo_q.delete();
    fifo_q.push_back(mk(900));
    fifo_q.push_back(mk(901));
    drive_fifo();
    #1;
    chk("rst_rden_gate", W'(bus.fifo_rden), W'(0));
    model_reset();
    drive_fifo();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();

    // Ten accepted beats with stalls in between.
    stall_cnt = 3;
    for (int k = 60; k < 70; k++) add(k);
    run_until_idle("t6", 100, cyc);
`ifdef TG_MPFIFO_DRAIN_STATS_EN
    chk("stats_10", W'(bus.drained_cnt), W'(10));
`else
    chk("stats_off", W'(bus.drained_cnt), W'(0));
`endif

    // Random ready and random refill rate.
    rnd_ready  = 1'b1;
    rnd_refill = 1'b1;
    for (int k = 100; k < 140; k++) add(k);
    run_until_idle("t7", 1000, cyc);
    rnd_ready  = 1'b0;
    rnd_refill = 1'b0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
